// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op codes, FSM states, iteration counts and decode helpers for md_unit.
package md_pkg;

    localparam logic [4:0] OP_MUL    = 5'b01111;
    localparam logic [4:0] OP_MULH   = 5'b10000;
    localparam logic [4:0] OP_MULHSU = 5'b10001;
    localparam logic [4:0] OP_MULHU  = 5'b10010;
    localparam logic [4:0] OP_DIV    = 5'b10011;
    localparam logic [4:0] OP_DIVU   = 5'b10100;
    localparam logic [4:0] OP_REM    = 5'b10101;
    localparam logic [4:0] OP_REMU   = 5'b10110;
    localparam logic [4:0] OP_MULW   = 5'b10111;
    localparam logic [4:0] OP_DIVW   = 5'b11000;
    localparam logic [4:0] OP_DIVUW  = 5'b11001;
    localparam logic [4:0] OP_REMW   = 5'b11010;
    localparam logic [4:0] OP_REMUW  = 5'b11011;

    localparam int N_FULL = 64;
    localparam int N_WORD = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    // sa/sb: operand is interpreted as signed; hi: upper product half wanted.
    typedef struct packed {
        logic ok;
        logic mul;
        logic div;
        logic rem;
        logic hi;
        logic word;
        logic sa;
        logic sb;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [4:0] op);
        op_info_t d;
        d = '0;
        case (op)
            OP_MUL:    begin d.ok = 1'b1; d.mul = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_MULH:   begin d.ok = 1'b1; d.mul = 1'b1; d.hi = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_MULHSU: begin d.ok = 1'b1; d.mul = 1'b1; d.hi = 1'b1; d.sa = 1'b1; end
            OP_MULHU:  begin d.ok = 1'b1; d.mul = 1'b1; d.hi = 1'b1; end
            OP_DIV:    begin d.ok = 1'b1; d.div = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_DIVU:   begin d.ok = 1'b1; d.div = 1'b1; end
            OP_REM:    begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_REMU:   begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; end
            OP_MULW:   begin d.ok = 1'b1; d.mul = 1'b1; d.word = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_DIVW:   begin d.ok = 1'b1; d.div = 1'b1; d.word = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_DIVUW:  begin d.ok = 1'b1; d.div = 1'b1; d.word = 1'b1; end
            OP_REMW:   begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; d.word = 1'b1; d.sa = 1'b1; d.sb = 1'b1; end
            OP_REMUW:  begin d.ok = 1'b1; d.div = 1'b1; d.rem = 1'b1; d.word = 1'b1; end
            default:   d = '0;
        endcase
        return d;
    endfunction

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    function automatic logic [63:0] mul_format(input logic word, input logic hi, input logic [127:0] p);
        if (word)
            return sext32(p[31:0]);
        else if (hi)
            return p[127:64];
        return p[63:0];
    endfunction

endpackage

// File: rtl/md_divider.sv
// rtl/md_divider.sv - restoring divider on unsigned magnitudes, one quotient bit per step.
module md_divider
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        step,
    input  logic        word,
    input  logic [63:0] dividend,
    input  logic [63:0] divisor,
    output logic        done,
    output logic [63:0] quotient,
    output logic [63:0] remainder
);

    logic [63:0] rem_q;
    logic [63:0] quo_q;
    logic [63:0] dsr_q;
    logic [6:0]  cnt_q;
    logic [63:0] rem_src;
    logic [63:0] quo_src;
    logic [63:0] dsr_src;
    logic [64:0] rem_shift;
    logic [64:0] trial;

    // The start cycle already performs the first step straight from the inputs,
    // so the registers hold the final answer once the counter reaches zero.
    // Word ops park the 32-bit dividend in the top half so 32 steps consume it.
    always_comb begin
        rem_src   = start ? 64'd0 : rem_q;
        quo_src   = start ? (word ? {dividend[31:0], 32'd0} : dividend) : quo_q;
        dsr_src   = start ? divisor : dsr_q;
        rem_shift = {rem_src, quo_src[63]};
        trial     = rem_shift - {1'b0, dsr_src};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
        end else if (start || step) begin
            rem_q <= trial[64] ? rem_shift[63:0] : trial[63:0];
            quo_q <= {quo_src[62:0], ~trial[64]};
            dsr_q <= dsr_src;
            cnt_q <= start ? (word ? 7'(N_WORD - 1) : 7'(N_FULL - 1)) : cnt_q - 7'd1;
        end
    end

    assign done      = (cnt_q == 7'd0);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit with IDLE/BUSY/DONE handshake.
// Define MD_FAST_MUL_EN to replace the shift-add multiplier with a single-cycle multiply.
module md_unit
    import md_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [4:0]  i_alu_control,
    input  logic [63:0] i_src_a,
    input  logic [63:0] i_src_b,
    input  logic        i_kill,
    output logic        o_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic [63:0] o_result
);

    state_t      state;
    op_info_t    info;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic [63:0] dividend_w;
    logic        neg_a;
    logic        neg_b;
    logic        div_zero;
    logic        div_ovf;
    logic        accept;
    logic        direct;
    logic [63:0] direct_result;

    logic        op_mul_q;
    logic        op_rem_q;
    logic        op_word_q;
    logic        neg_a_q;
    logic        neg_b_q;

    logic        div_start;
    logic        div_step;
    logic        div_done;
    logic [63:0] quotient;
    logic [63:0] remainder;
    logic [63:0] quo_fix;
    logic [63:0] rem_fix;
    logic [63:0] div_value;
    logic [63:0] div_res;

    logic        busy_last;
    logic [63:0] busy_result;

    always_comb begin
        info       = decode_op(i_alu_control);
        a_ext      = info.word ? {{32{info.sa & i_src_a[31]}}, i_src_a[31:0]} : i_src_a;
        b_ext      = info.word ? {{32{info.sb & i_src_b[31]}}, i_src_b[31:0]} : i_src_b;
        neg_a      = info.sa & a_ext[63];
        neg_b      = info.sb & b_ext[63];
        mag_a      = neg_a ? -a_ext : a_ext;
        mag_b      = neg_b ? -b_ext : b_ext;
        dividend_w = info.word ? sext32(i_src_a[31:0]) : i_src_a;
        div_zero   = (b_ext == 64'd0);
        div_ovf    = info.sa && (b_ext == '1) &&
                     (info.word ? (i_src_a[31:0] == 32'h8000_0000)
                                : (i_src_a == {1'b1, 63'd0}));
    end

    assign accept  = (state == S_IDLE) && i_valid && !i_kill && !i_rst;
    assign o_ready = (state == S_IDLE);
    assign o_busy  = (state == S_BUSY) || accept;

`ifndef MD_FAST_MUL_EN
    logic [127:0] acc_q;
    logic [127:0] mcand_q;
    logic [127:0] prod_fix;
    logic [63:0]  mplier_q;
    logic [6:0]   mul_cnt_q;
    logic         op_hi_q;
    logic         mul_start;
    logic         mul_step;

    assign mul_start = accept && !direct && info.mul;
    assign mul_step  = (state == S_BUSY) && op_mul_q && !i_kill && (mul_cnt_q != 7'd0);

    // Like the divider, the accepting edge performs the first shift-add step.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mul_cnt_q <= '0;
            op_hi_q   <= 1'b0;
        end else if (mul_start) begin
            acc_q     <= mag_b[0] ? {64'd0, mag_a} : 128'd0;
            mcand_q   <= {63'd0, mag_a, 1'b0};
            mplier_q  <= {1'b0, mag_b[63:1]};
            mul_cnt_q <= info.word ? 7'(N_WORD - 1) : 7'(N_FULL - 1);
            op_hi_q   <= info.hi;
        end else if (mul_step) begin
            acc_q     <= acc_q + (mplier_q[0] ? mcand_q : 128'd0);
            mcand_q   <= {mcand_q[126:0], 1'b0};
            mplier_q  <= {1'b0, mplier_q[63:1]};
            mul_cnt_q <= mul_cnt_q - 7'd1;
        end
    end

    assign prod_fix    = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    assign busy_last   = op_mul_q ? (mul_cnt_q == 7'd0) : div_done;
    assign busy_result = op_mul_q ? mul_format(op_word_q, op_hi_q, prod_fix) : div_res;
`else
    logic [127:0] fa;
    logic [127:0] fb;
    logic [127:0] fast_prod;

    // 65x65 signed product; the low 128 bits are all any result slice needs.
    assign fa          = {{64{info.sa & a_ext[63]}}, a_ext};
    assign fb          = {{64{info.sb & b_ext[63]}}, b_ext};
    assign fast_prod   = fa * fb;
    assign busy_last   = div_done;
    assign busy_result = div_res;
`endif

    always_comb begin
        direct        = 1'b1;
        direct_result = '0;
        if (!info.ok)
            direct_result = '0;
        else if (info.div && div_zero)
            direct_result = info.rem ? dividend_w : '1;
        else if (info.div && div_ovf)
            direct_result = info.rem ? 64'd0 : dividend_w;
`ifdef MD_FAST_MUL_EN
        else if (info.mul)
            direct_result = mul_format(info.word, info.hi, fast_prod);
`endif
        else
            direct = 1'b0;
    end

    assign div_start = accept && !direct && info.div;
    assign div_step  = (state == S_BUSY) && !op_mul_q && !i_kill && !div_done;

    md_divider u_divider (
        .clk       (i_clk),
        .rst       (i_rst),
        .start     (div_start),
        .step      (div_step),
        .word      (info.word),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        quo_fix   = (neg_a_q ^ neg_b_q) ? -quotient : quotient;
        rem_fix   = neg_a_q ? -remainder : remainder;
        div_value = op_rem_q ? rem_fix : quo_fix;
        div_res   = op_word_q ? sext32(div_value[31:0]) : div_value;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            o_done    <= 1'b0;
            o_result  <= '0;
            op_mul_q  <= 1'b0;
            op_rem_q  <= 1'b0;
            op_word_q <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_mul_q  <= info.mul;
                        op_rem_q  <= info.rem;
                        op_word_q <= info.word;
                        neg_a_q   <= neg_a;
                        neg_b_q   <= neg_b;
                        if (direct) begin
                            state    <= S_DONE;
                            o_done   <= 1'b1;
                            o_result <= direct_result;
                        end else begin
                            state <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    if (i_kill) begin
                        state <= S_IDLE;
                    end else if (busy_last) begin
                        state    <= S_DONE;
                        o_done   <= 1'b1;
                        o_result <= busy_result;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed self-checking bench for md_unit.
module tb_md_unit;
    import md_pkg::*;

`ifdef MD_FAST_MUL_EN
    localparam int MUL64_LAT = 1;
    localparam int MUL32_LAT = 1;
`else
    localparam int MUL64_LAT = 65;
    localparam int MUL32_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        kill;
    logic [4:0]  ctl;
    logic [63:0] a;
    logic [63:0] b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    md_unit dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_alu_control (ctl),
        .i_src_a       (a),
        .i_src_b       (b),
        .i_kill        (kill),
        .o_ready       (ready),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [63:0] opa,
                          input logic [63:0] opb, input int lat, input logic [63:0] exp);
        int n;
        valid = 1'b1;
        ctl   = op;
        a     = opa;
        b     = opb;
        #1;
        check($sformatf("%s accept_rdy_busy", tag), {62'd0, ready, busy}, 64'd3);
        tick();
        valid = 1'b0;
        n     = 1;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        check($sformatf("%s latency", tag), 64'(n), 64'(lat));
        check($sformatf("%s result", tag), result, exp);
        tick();
        check($sformatf("%s back_idle", tag), {61'd0, ready, busy, done}, 64'd4);
        check($sformatf("%s hold", tag), result, exp);
    endtask

    task automatic watch_no_done(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) seen++;
        end
        check(tag, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        kill  = 1'b0;
        ctl   = 5'd0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        check("reset flags", {61'd0, ready, busy, done}, 64'd4);
        check("reset result", result, 64'd0);
        rst = 1'b0;
        #1;

        run_op("div_m7_2",   OP_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("rem_m7_2",   OP_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 65, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("divu_by0",   OP_DIVU,   64'd5, 64'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("remu_by0",   OP_REMU,   64'd5, 64'd0, 1, 64'd5);
        run_op("divw_ovf",   OP_DIVW,   64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 1,
               64'hFFFF_FFFF_8000_0000);
        run_op("mulh_m1",    OP_MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL64_LAT, 64'd0);
        run_op("mulw_big",   OP_MULW,   64'h0000_0000_7FFF_FFFF, 64'd2, MUL32_LAT, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhu_max",  OP_MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL64_LAT,
               64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhsu_m1",  OP_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, MUL64_LAT,
               64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mul_wide",   OP_MUL,    64'h0000_0001_0000_0003, 64'd5, MUL64_LAT, 64'h0000_0005_0000_000F);
        run_op("divuw_100_7", OP_DIVUW, 64'hABCD_0000_0000_0064, 64'd7, 33, 64'd14);
        run_op("remw_m100_7", OP_REMW,  64'h0000_0000_FFFF_FF9C, 64'd7, 33, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("div_ovf",    OP_DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1,
               64'h8000_0000_0000_0000);
        run_op("rem_ovf",    OP_REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 64'd0);
        run_op("div_100_m7", OP_DIV,    64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 65, 64'hFFFF_FFFF_FFFF_FFF2);
        run_op("rem_100_m7", OP_REM,    64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 65, 64'd2);
        run_op("bad_code",   5'b00000,  64'd9, 64'd9, 1, 64'd0);

        // kill together with valid in IDLE: request must be dropped
        valid = 1'b1;
        kill  = 1'b1;
        ctl   = OP_DIV;
        a     = 64'd50;
        b     = 64'd5;
        #1;
        check("kill_idle busy", {63'd0, busy}, 64'd0);
        tick();
        valid = 1'b0;
        kill  = 1'b0;
        check("kill_idle flags", {61'd0, ready, busy, done}, 64'd4);
        watch_no_done("kill_idle no_done", 80);

        // kill in the tenth BUSY cycle of a DIV
        valid = 1'b1;
        ctl   = OP_DIV;
        a     = 64'hFFFF_FFFF_FFFF_FFF9;
        b     = 64'd2;
        tick();
        valid = 1'b0;
        repeat (9) tick();
        check("kill_busy in_busy", {61'd0, ready, busy, done}, 64'd2);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill_busy flags", {61'd0, ready, busy, done}, 64'd4);
        watch_no_done("kill_busy no_done", 80);
        run_op("mul_after_kill", OP_MUL, 64'd3, 64'd4, MUL64_LAT, 64'd12);

        // reset mid-BUSY
        valid = 1'b1;
        ctl   = OP_DIVU;
        a     = 64'd100;
        b     = 64'd7;
        tick();
        valid = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        check("rst_busy flags", {61'd0, ready, busy, done}, 64'd4);
        check("rst_busy result", result, 64'd0);
        rst = 1'b0;
        watch_no_done("rst_busy no_done", 80);
        run_op("divu_after_rst", OP_DIVU, 64'd100, 64'd7, 65, 64'd14);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
